// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-engine command path: op codes, command
// field positions and the scheduler FSM encoding.
package vga_pkg;

    typedef enum logic [1:0] {
        OP_POS = 2'd0,
        OP_ATT = 2'd1,
        OP_FWR = 2'd2,
        OP_BG  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam int CMD_W      = 32;
    localparam int OP_LSB     = 30;
    localparam int SEL_LSB    = 25;
    localparam int SEL_W      = 5;
    localparam int X_LSB      = 15;
    localparam int X_W        = 10;
    localparam int Y_LSB      = 6;
    localparam int Y_W        = 9;
    localparam int VIS_BIT    = 5;
    localparam int FWADDR_LSB = 4;
    localparam int FWADDR_W   = 11;
    localparam int FWDATA_LSB = 0;
    localparam int FWDATA_W   = 4;
    localparam int BG_LSB     = 0;
    localparam int BG_W       = 2;

    function automatic op_e cmd_op(input logic [CMD_W-1:0] cmd);
        return op_e'(cmd[OP_LSB +: 2]);
    endfunction

endpackage

// File: rtl/sync_level.sv
// N-flop level synchroniser for a slowly changing signal crossing into this
// clock domain. Output is the oldest stage.
module sync_level #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    generate
        if (STAGES == 1) begin : g_single
            always_comb sync_d = d;
        end else begin : g_chain
            always_comb sync_d = {sync_q[STAGES-2:0], d};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value from before this edge, giving a true shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sprite_cmd_sched.sv
// Round-robin scheduler serialising two requesters' commands onto the pixel
// engine's load strobes; sprite and background updates wait for vblank.
module sprite_cmd_sched
    import vga_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit GATE_FW     = 1'b0
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        vblank,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req_cmd,
    output logic [1:0]  req_ready,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [4:0]  sprite_sel,
    output logic        visable,
    output logic        load_pos,
    output logic        load_att,
    output logic [1:0]  background_sel,
    output logic        bchange_active,
    output logic [10:0] fwaddr,
    output logic [3:0]  fwdata,
    output logic        fwenable,
    output logic        fchange_active,
    output logic        busy
);

    logic vblank_s;

    sync_level #(.STAGES(SYNC_STAGES)) u_vblank_sync (
        .clk   (clk_100),
        .rst_n (rst),
        .d     (vblank),
        .q     (vblank_s)
    );

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        win_q, win_d;
    logic        last_grant_q, last_grant_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [4:0]  sel_q, sel_d;
    logic        vis_q, vis_d;
    logic [1:0]  bg_q, bg_d;
    logic [10:0] fwaddr_q, fwaddr_d;
    logic [3:0]  fwdata_q, fwdata_d;

    logic [1:0]       eligible;
    logic             win;
    logic [CMD_W-1:0] win_cmd;

    // A request competes only if its own op may run now, so a gated request
    // never starves an always-eligible framebuffer write on the other port.
    always_comb begin
        eligible = '0;
        for (int n = 0; n < 2; n++) begin
            eligible[n] = req_valid[n] &
                          (vblank_s | ((cmd_op(req_cmd[CMD_W*n +: CMD_W]) == OP_FWR) && !GATE_FW));
        end
        if (eligible == 2'b11) begin
            win = ~last_grant_q;
        end else begin
            win = eligible[1];
        end
        win_cmd = win ? req_cmd[63:32] : req_cmd[31:0];
    end

    // Fields are captured at grant time so the data outputs are already
    // valid in SETUP; fields the op does not use keep their old value.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        sel_d        = sel_q;
        vis_d        = vis_q;
        bg_d         = bg_q;
        fwaddr_d     = fwaddr_q;
        fwdata_d     = fwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d      = ST_SETUP;
                    win_d        = win;
                    last_grant_d = win;
                    op_d         = cmd_op(win_cmd);
                    case (cmd_op(win_cmd))
                        OP_POS: begin
                            sel_d = win_cmd[SEL_LSB +: SEL_W];
                            x_d   = win_cmd[X_LSB +: X_W];
                            y_d   = win_cmd[Y_LSB +: Y_W];
                        end
                        OP_ATT: begin
                            sel_d = win_cmd[SEL_LSB +: SEL_W];
                            vis_d = win_cmd[VIS_BIT];
                        end
                        OP_FWR: begin
                            fwaddr_d = win_cmd[FWADDR_LSB +: FWADDR_W];
                            fwdata_d = win_cmd[FWDATA_LSB +: FWDATA_W];
                        end
                        default: begin
                            bg_d = win_cmd[BG_LSB +: BG_W];
                        end
                    endcase
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_ACK;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_POS;
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            sel_q        <= '0;
            vis_q        <= 1'b0;
            bg_q         <= '0;
            fwaddr_q     <= '0;
            fwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sel_q        <= sel_d;
            vis_q        <= vis_d;
            bg_q         <= bg_d;
            fwaddr_q     <= fwaddr_d;
            fwdata_q     <= fwdata_d;
        end
    end

    // Strobes and handshakes decode straight from registered state, so an
    // asynchronous reset clears them in the same instant as the FSM.
    always_comb begin
        load_pos       = (state_q == ST_STROBE) && (op_q == OP_POS);
        load_att       = (state_q == ST_STROBE) && (op_q == OP_ATT);
        fwenable       = (state_q == ST_STROBE) && (op_q == OP_FWR);
        bchange_active = (state_q == ST_STROBE) && (op_q == OP_BG);
        fchange_active = ((state_q == ST_SETUP) || (state_q == ST_STROBE)) && (op_q == OP_FWR);
        req_ready      = '0;
        if (state_q == ST_ACK) begin
            req_ready[win_q] = 1'b1;
        end
        busy = (state_q != ST_IDLE);
    end

    assign x              = x_q;
    assign y              = y_q;
    assign sprite_sel     = sel_q;
    assign visable        = vis_q;
    assign background_sel = bg_q;
    assign fwaddr         = fwaddr_q;
    assign fwdata         = fwdata_q;

endmodule

// File: tb/tb_sprite_cmd_sched.sv
// Directed bench for sprite_cmd_sched: reset, timing, vblank gating, round
// robin, non-blocking arbitration, mid-command vblank drop, reset in flight.
module tb_sprite_cmd_sched;

    localparam int SYNC = 2;

    logic        clk_100 = 1'b0;
    logic        rst;
    logic        vblank;
    logic [1:0]  req_valid;
    logic [63:0] req_cmd;
    logic [1:0]  req_ready;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [4:0]  sprite_sel;
    logic        visable;
    logic        load_pos;
    logic        load_att;
    logic [1:0]  background_sel;
    logic        bchange_active;
    logic [10:0] fwaddr;
    logic [3:0]  fwdata;
    logic        fwenable;
    logic        fchange_active;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sprite_cmd_sched #(.SYNC_STAGES(SYNC), .GATE_FW(1'b0)) dut (
        .clk_100        (clk_100),
        .rst            (rst),
        .vblank         (vblank),
        .req_valid      (req_valid),
        .req_cmd        (req_cmd),
        .req_ready      (req_ready),
        .x              (x),
        .y              (y),
        .sprite_sel     (sprite_sel),
        .visable        (visable),
        .load_pos       (load_pos),
        .load_att       (load_att),
        .background_sel (background_sel),
        .bchange_active (bchange_active),
        .fwaddr         (fwaddr),
        .fwdata         (fwdata),
        .fwenable       (fwenable),
        .fchange_active (fchange_active),
        .busy           (busy)
    );

    always #5 clk_100 = ~clk_100;

    function automatic logic [31:0] mk_pos(input logic [4:0] sel, input logic [9:0] px, input logic [8:0] py);
        return {2'd0, sel, px, py, 6'd0};
    endfunction

    function automatic logic [31:0] mk_att(input logic [4:0] sel, input logic vis);
        return {2'd1, sel, 19'd0, vis, 5'd0};
    endfunction

    function automatic logic [31:0] mk_fwr(input logic [10:0] addr, input logic [3:0] data);
        return {2'd2, 15'd0, addr, data};
    endfunction

    function automatic logic [31:0] mk_bg(input logic [1:0] bg);
        return {2'd3, 28'd0, bg};
    endfunction

    function automatic int who(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return 99;
    endfunction

    task automatic apply_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        repeat (2) @(negedge clk_100);
        rst = 1'b1;
        @(negedge clk_100);
    endtask

    task automatic set_vblank(input logic v);
        vblank = v;
        repeat (SYNC + 2) @(negedge clk_100);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        vblank    = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        @(negedge clk_100);
        n_checks++;
        if ({busy, req_ready, load_pos, load_att, fwenable, bchange_active, fchange_active} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, req_ready, load_pos, load_att, fwenable, bchange_active, fchange_active});
        end
        n_checks++;
        if ({x, y, sprite_sel, visable, background_sel, fwaddr, fwdata} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {x, y, sprite_sel, visable, background_sel, fwaddr, fwdata});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk_100);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_pos();
        int pos_cnt = 0, pos_cyc = -1, rdy_cyc = -1, rdy_cnt = 0;
        logic [9:0] sx = '0;
        logic [8:0] sy = '0;
        logic [4:0] ss = '0;
        logic [9:0] x1 = '0;
        apply_reset();
        set_vblank(1'b1);
        req_cmd[31:0] = mk_pos(5'd3, 10'd100, 9'd50);
        req_valid     = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_100);
            if (c == 1) x1 = x;
            if (load_pos) begin
                pos_cnt++;
                pos_cyc = c;
                sx = x; sy = y; ss = sprite_sel;
            end
            if (req_ready != 2'b00) begin
                rdy_cnt++;
                if (req_ready == 2'b01) rdy_cyc = c;
                req_valid = 2'b00;
            end
        end
        n_checks++;
        if (x1 !== 10'd100) begin
            n_fail++;
            $display("FAIL pos_data_setup_x: got %0d expected 100", x1);
        end
        n_checks++;
        if (pos_cnt !== 1 || pos_cyc !== 2) begin
            n_fail++;
            $display("FAIL pos_strobe: got count %0d cycle %0d expected count 1 cycle 2", pos_cnt, pos_cyc);
        end
        n_checks++;
        if (sx !== 10'd100 || sy !== 9'd50 || ss !== 5'd3) begin
            n_fail++;
            $display("FAIL pos_fields: got x=%0d y=%0d sel=%0d expected x=100 y=50 sel=3", sx, sy, ss);
        end
        n_checks++;
        if (rdy_cnt !== 1 || rdy_cyc !== 3) begin
            n_fail++;
            $display("FAIL pos_ready: got count %0d cycle %0d expected count 1 cycle 3", rdy_cnt, rdy_cyc);
        end
    endtask

    task automatic test_gating();
        int bad = 0, att_cyc = -1, rdy_cyc = -1;
        logic sv = 1'b0;
        logic [4:0] ss = '0;
        apply_reset();
        set_vblank(1'b0);
        req_cmd[63:32] = mk_att(5'd7, 1'b1);
        req_valid      = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (load_att || busy || req_ready != 2'b00) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL gate_hold: got %0d active cycles expected 0", bad);
        end
        vblank = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (load_att && att_cyc < 0) begin
                att_cyc = c; sv = visable; ss = sprite_sel;
            end
            if (req_ready == 2'b10 && rdy_cyc < 0) begin
                rdy_cyc   = c;
                req_valid = 2'b00;
            end
        end
        n_checks++;
        if (att_cyc !== SYNC + 2) begin
            n_fail++;
            $display("FAIL gate_att_latency: got %0d expected %0d", att_cyc, SYNC + 2);
        end
        n_checks++;
        if (sv !== 1'b1 || ss !== 5'd7 || rdy_cyc !== SYNC + 3) begin
            n_fail++;
            $display("FAIL gate_att_fields: got vis=%b sel=%0d ready_cyc=%0d expected vis=1 sel=7 ready_cyc=%0d",
                     sv, ss, rdy_cyc, SYNC + 3);
        end
    endtask

    task automatic test_round_robin();
        int n_en = 0, n_rdy = 0, fch_bad = 0;
        int en_cyc[4];
        int rdy_cyc[4];
        int rdy_who[4];
        logic [10:0] en_addr[4];
        logic [3:0]  en_data[4];
        int          exp_cyc[4]  = '{2, 6, 10, 14};
        logic [10:0] exp_addr[4] = '{11'h011, 11'h022, 11'h011, 11'h022};
        logic [3:0]  exp_data[4] = '{4'h1, 4'h2, 4'h1, 4'h2};
        apply_reset();
        vblank         = 1'b0;
        req_cmd[31:0]  = mk_fwr(11'h011, 4'h1);
        req_cmd[63:32] = mk_fwr(11'h022, 4'h2);
        req_valid      = 2'b11;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_100);
            if (fwenable && n_en < 4) begin
                en_cyc[n_en] = c; en_addr[n_en] = fwaddr; en_data[n_en] = fwdata;
                if (!fchange_active) fch_bad++;
                n_en++;
            end
            if (req_ready != 2'b00 && n_rdy < 4) begin
                rdy_cyc[n_rdy] = c; rdy_who[n_rdy] = who(req_ready);
                n_rdy++;
            end
        end
        req_valid = 2'b00;
        n_checks++;
        if (n_en !== 4 || n_rdy !== 4) begin
            n_fail++;
            $display("FAIL rr_counts: got strobes %0d readies %0d expected 4 and 4", n_en, n_rdy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (en_cyc[i] !== exp_cyc[i] || en_addr[i] !== exp_addr[i] || en_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL rr_strobe_%0d: got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                             i, en_cyc[i], en_addr[i], en_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
                end
                n_checks++;
                if (rdy_cyc[i] !== exp_cyc[i] + 1 || rdy_who[i] !== (i % 2)) begin
                    n_fail++;
                    $display("FAIL rr_grant_%0d: got cyc %0d requester %0d expected cyc %0d requester %0d",
                             i, rdy_cyc[i], rdy_who[i], exp_cyc[i] + 1, i % 2);
                end
            end
        end
        n_checks++;
        if (fch_bad !== 0) begin
            n_fail++;
            $display("FAIL rr_fchange: got %0d strobes without window expected 0", fch_bad);
        end
        repeat (3) @(negedge clk_100);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_non_blocking();
        int fw_cyc = -1, r1_cyc = -1, r0_cnt = 0, bg_cnt = 0, busy_end = 0;
        int bg_cyc = -1, r0_cyc = -1;
        logic [10:0] sa = '0;
        logic [3:0]  sd = '0;
        logic [1:0]  sb = '0;
        apply_reset();
        set_vblank(1'b0);
        req_cmd[31:0]  = mk_bg(2'd2);
        req_cmd[63:32] = mk_fwr(11'h7FF, 4'hA);
        req_valid      = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_100);
            if (fwenable && fw_cyc < 0) begin
                fw_cyc = c; sa = fwaddr; sd = fwdata;
            end
            if (req_ready[0]) r0_cnt++;
            if (bchange_active) bg_cnt++;
            if (req_ready[1] && r1_cyc < 0) begin
                r1_cyc       = c;
                req_valid[1] = 1'b0;
            end
            if (c == 10) busy_end = busy;
        end
        n_checks++;
        if (fw_cyc !== 2 || sa !== 11'h7FF || sd !== 4'hA || r1_cyc !== 3) begin
            n_fail++;
            $display("FAIL nb_fwr: got cyc %0d addr %h data %h ready_cyc %0d expected 2 7ff a 3",
                     fw_cyc, sa, sd, r1_cyc);
        end
        n_checks++;
        if (r0_cnt !== 0 || bg_cnt !== 0 || busy_end !== 0) begin
            n_fail++;
            $display("FAIL nb_bg_pending: got ready0 %0d bchange %0d busy %0d expected 0 0 0",
                     r0_cnt, bg_cnt, busy_end);
        end
        vblank = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (bchange_active && bg_cyc < 0) begin
                bg_cyc = c; sb = background_sel;
            end
            if (req_ready[0] && r0_cyc < 0) begin
                r0_cyc       = c;
                req_valid[0] = 1'b0;
            end
        end
        n_checks++;
        if (bg_cyc !== SYNC + 2 || sb !== 2'd2 || r0_cyc !== SYNC + 3) begin
            n_fail++;
            $display("FAIL nb_bg_release: got cyc %0d sel %0d ready_cyc %0d expected %0d 2 %0d",
                     bg_cyc, sb, r0_cyc, SYNC + 2, SYNC + 3);
        end
    endtask

    task automatic test_vblank_drop();
        int pos_cyc = -1, rdy_cyc = -1;
        logic [9:0] sx = '0;
        logic [8:0] sy = '0;
        apply_reset();
        set_vblank(1'b1);
        req_cmd[31:0] = mk_pos(5'd9, 10'd639, 9'd479);
        req_valid     = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_100);
            if (c == 1) vblank = 1'b0;
            if (load_pos && pos_cyc < 0) begin
                pos_cyc = c; sx = x; sy = y;
            end
            if (req_ready == 2'b01 && rdy_cyc < 0) begin
                rdy_cyc   = c;
                req_valid = 2'b00;
            end
        end
        n_checks++;
        if (pos_cyc !== 2 || rdy_cyc !== 3) begin
            n_fail++;
            $display("FAIL drop_complete: got strobe %0d ready %0d expected 2 3", pos_cyc, rdy_cyc);
        end
        n_checks++;
        if (sx !== 10'd639 || sy !== 9'd479) begin
            n_fail++;
            $display("FAIL drop_fields: got x=%0d y=%0d expected 639 479", sx, sy);
        end
    endtask

    task automatic test_reset_in_flight();
        int rdy_seen = 0, fw_cyc = -1, rdy_cyc = -1, rdy_who = -1;
        logic strobe_seen = 1'b0;
        logic [10:0] sa = '0;
        apply_reset();
        set_vblank(1'b1);
        req_cmd[31:0] = mk_pos(5'd4, 10'd20, 9'd30);
        req_valid     = 2'b01;
        repeat (2) @(negedge clk_100);
        strobe_seen = load_pos;
        n_checks++;
        if (strobe_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL rif_in_strobe: got load_pos %b expected 1", strobe_seen);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, req_ready, load_pos, load_att, fwenable, bchange_active, fchange_active} !== 8'd0 ||
            {x, y, sprite_sel, visable, background_sel, fwaddr, fwdata} !== 42'd0) begin
            n_fail++;
            $display("FAIL rif_async_clear: got ctrl %b data %h expected all 0",
                     {busy, req_ready, load_pos, load_att, fwenable, bchange_active, fchange_active},
                     {x, y, sprite_sel, visable, background_sel, fwaddr, fwdata});
        end
        req_valid = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_100);
            if (req_ready != 2'b00) rdy_seen++;
            if (c == 2) rst = 1'b1;
        end
        n_checks++;
        if (rdy_seen !== 0) begin
            n_fail++;
            $display("FAIL rif_no_ack: got %0d ready pulses expected 0", rdy_seen);
        end
        req_cmd[31:0]  = mk_fwr(11'h100, 4'h3);
        req_cmd[63:32] = mk_fwr(11'h200, 4'h5);
        req_valid      = 2'b11;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_100);
            if (fwenable && fw_cyc < 0) begin
                fw_cyc = c; sa = fwaddr;
            end
            if (req_ready != 2'b00 && rdy_cyc < 0) begin
                rdy_cyc = c; rdy_who = who(req_ready);
            end
        end
        req_valid = 2'b00;
        n_checks++;
        if (fw_cyc !== 2 || sa !== 11'h100 || rdy_cyc !== 3 || rdy_who !== 0) begin
            n_fail++;
            $display("FAIL rif_first_tie: got cyc %0d addr %h ready_cyc %0d requester %0d expected 2 100 3 0",
                     fw_cyc, sa, rdy_cyc, rdy_who);
        end
    endtask

    initial begin
        rst       = 1'b0;
        vblank    = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        test_reset();
        test_single_pos();
        test_gating();
        test_round_robin();
        test_non_blocking();
        test_vblank_drop();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
